// File: rtl/codec_sample_receiver_pkg.sv
// Shared audio constants and types for the codec sample path.
package codec_sample_receiver_pkg;

   localparam int unsigned SAMPLE_W   = 16;
   // FIFO depth shared with the recorder on the consumer side
   localparam int unsigned FIFO_DEPTH = 16;

   typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/codec_sample_receiver_if.sv
// Valid/ready sample stream from the receiver to a downstream consumer.
interface codec_sample_receiver_if
   import codec_sample_receiver_pkg::*;
#(
   parameter int unsigned DATA_W = SAMPLE_W
) ();

   logic              sample_valid;
   logic              sample_ready;
   logic [DATA_W-1:0] sample_out;

   modport master (
      output sample_valid,
      output sample_out,
      input  sample_ready
   );

   modport slave (
      input  sample_valid,
      input  sample_out,
      output sample_ready
   );

endinterface

// File: rtl/codec_sample_receiver_sync_fifo.sv
// First-word fall-through synchronous FIFO; extra pointer MSB separates full from empty.
module codec_sample_receiver_sync_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 16,
   localparam int unsigned AddrW = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [AddrW:0]    count_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AddrW:0]    wr_ptr_q, wr_ptr_d;
   logic [AddrW:0]    rd_ptr_q, rd_ptr_d;
   logic              rd_en;

   assign count_o = wr_ptr_q - rd_ptr_q;
   assign full_o  = (count_o == (AddrW + 1)'(DEPTH));
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign rd_en   = pop_i & ~empty_o;
   // Drive zero while empty so the head output is defined after reset
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

   // Pointer next-state; wrap comes for free from the fixed width
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers, emptied asynchronously by reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are not reset
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/codec_sample_receiver.sv
// Captures a codec ADC sample per new_frame rising edge, decimates, and queues it for a consumer.
module codec_sample_receiver
   import codec_sample_receiver_pkg::*;
#(
   parameter int unsigned DATA_W = SAMPLE_W,
   parameter int unsigned DEPTH  = FIFO_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   parameter int unsigned DECIM  = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   new_frame,
   input  logic [DATA_W-1:0]      sample_in,
   input  logic                   capture_en,
   input  logic                   clear_overflow,
   codec_sample_receiver_if.master rx,
   output logic                   new_sample_captured,
   output logic                   overflow,
   output logic [ADDR_W:0]        fill_level
);

   logic       new_frame_q;
   logic [7:0] decim_cnt_q, decim_cnt_d;
   logic       overflow_q, overflow_d;
   logic       captured_q;
   logic       frame_edge, take, push, pop, full, empty, full_eff;

   assign frame_edge = new_frame & ~new_frame_q;
   assign take       = frame_edge & capture_en & (decim_cnt_q == 8'(DECIM - 1));
   assign pop        = rx.sample_valid & rx.sample_ready;
   // A pop in the same cycle frees the slot a full FIFO needs
   assign full_eff   = full & ~pop;
   assign push       = take & ~full_eff;

   assign rx.sample_valid     = ~empty;
   assign new_sample_captured = captured_q;
   assign overflow            = overflow_q;

   // Decimation count and sticky overflow next-state
   always_comb begin
      decim_cnt_d = decim_cnt_q;
      if (frame_edge && capture_en) begin
         decim_cnt_d = take ? 8'd0 : decim_cnt_q + 8'd1;
      end
      overflow_d = overflow_q;
      if (take && full_eff)    overflow_d = 1'b1;
      else if (clear_overflow) overflow_d = 1'b0;
   end

   // Edge register resets high so a level held across reset release is not a frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         new_frame_q <= 1'b1;
         decim_cnt_q <= '0;
         overflow_q  <= 1'b0;
         captured_q  <= 1'b0;
      end else begin
         new_frame_q <= new_frame;
         decim_cnt_q <= decim_cnt_d;
         overflow_q  <= overflow_d;
         captured_q  <= push;
      end
   end

   codec_sample_receiver_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (sample_in),
      .rdata_o (rx.sample_out),
      .full_o  (full),
      .empty_o (empty),
      .count_o (fill_level)
   );

endmodule
